// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial adder/subtractor with a four-phase req/fin handshake.
//   Processes Chunk bits per clock, so a result takes N = Width/Chunk cycles.
//   Width >= 2 and Chunk must divide Width.
//   Optional macro ADDSUB_SEQ_SAT_EN adds the sat input. When sat is latched
//   high and the result overflows, so clamps to the signed limit.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req           request, four-phase handshake
//   op[1:0]       00 ADD x+y, 01 SUB x-y, 10 RSUB y-x, 11 ADC x+y+couto
//   x, y          operands, latched on the capture edge
//   sat           (ADDSUB_SEQ_SAT_EN only) saturate on signed overflow
//   fin           result valid / handshake acknowledge
//   so            result
//   couto         carry out (ADD/ADC) or unsigned borrow (SUB/RSUB)
//   zero, neg     so == 0, so[Width-1]
//   ovf           signed overflow
module addsub_seq #(
  parameter int unsigned Width = 32,
  parameter int unsigned Chunk = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y,
`ifdef ADDSUB_SEQ_SAT_EN
  input  logic             sat,
`endif
  output logic             fin,
  output logic [Width-1:0] so,
  output logic             couto,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned N    = Width / Chunk;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdxW = $clog2(Width);
  localparam int unsigned SumW = Chunk + 1;

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpRsub = 2'b10;
  localparam logic [1:0] OpAdc  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   a_q, a_d;
  logic [Width-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [Width-1:0]   sum_q, sum_d;
  logic               fin_q, fin_d;
  logic [Width-1:0]   so_q, so_d;
  logic               couto_q, couto_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
`ifdef ADDSUB_SEQ_SAT_EN
  logic               sat_q, sat_d;
`endif

  logic [IdxW-1:0]    base_c;
  logic [SumW-1:0]    chunk_sum_c;
  logic [Width-1:0]   res_c;
  logic [Width-1:0]   final_c;
  logic               ovf_c;

  assign fin   = fin_q;
  assign so    = so_q;
  assign couto = couto_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      fin_q   <= 1'b0;
      so_q    <= '0;
      couto_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ADDSUB_SEQ_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      fin_q   <= fin_d;
      so_q    <= so_d;
      couto_q <= couto_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`ifdef ADDSUB_SEQ_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    fin_d   = fin_q;
    so_d    = so_q;
    couto_d = couto_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`ifdef ADDSUB_SEQ_SAT_EN
    sat_d   = sat_q;
`endif

    // One chunk of the ripple add; b_q already holds the inverted subtrahend
    base_c      = IdxW'(cnt_q) * IdxW'(Chunk);
    chunk_sum_c = {1'b0, a_q[base_c +: Chunk]} + {1'b0, b_q[base_c +: Chunk]}
                  + SumW'(carry_q);
    res_c                  = sum_q;
    res_c[base_c +: Chunk] = chunk_sum_c[Chunk-1:0];

    // With the subtrahend pre-inverted, the add-overflow rule covers subtract too
    ovf_c   = (a_q[Width-1] == b_q[Width-1]) && (res_c[Width-1] != a_q[Width-1]);
    final_c = res_c;
`ifdef ADDSUB_SEQ_SAT_EN
    // On overflow the true sign is the shared operand sign, i.e. a_q's sign
    if (sat_q && ovf_c) begin
      final_c = a_q[Width-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          case (op)
            OpSub: begin
              a_d = x; b_d = ~y; carry_d = 1'b1; sub_d = 1'b1;
            end
            OpRsub: begin
              a_d = y; b_d = ~x; carry_d = 1'b1; sub_d = 1'b1;
            end
            OpAdc: begin
              a_d = x; b_d = y; carry_d = couto_q; sub_d = 1'b0;
            end
            OpAdd: begin
              a_d = x; b_d = y; carry_d = 1'b0; sub_d = 1'b0;
            end
            default: begin
              a_d = x; b_d = y; carry_d = 1'b0; sub_d = 1'b0;
            end
          endcase
`ifdef ADDSUB_SEQ_SAT_EN
          sat_d   = sat;
`endif
          cnt_d   = '0;
          sum_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = res_c;
        carry_d = chunk_sum_c[Chunk];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          so_d    = final_c;
          couto_d = sub_q ? ~chunk_sum_c[Chunk] : chunk_sum_c[Chunk];
          zero_d  = (final_c == '0);
          neg_d   = final_c[Width-1];
          ovf_d   = ovf_c;
          fin_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!req) begin
          fin_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fin_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq at Width=32, Chunk=8.
module tb_addsub_seq;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] RSUB = 2'b10;
  localparam logic [1:0] ADC  = 2'b11;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        fin;
  logic [31:0] so;
  logic        couto;
  logic        zero;
  logic        neg;
  logic        ovf;
`ifdef ADDSUB_SEQ_SAT_EN
  logic        sat;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  addsub_seq #(.Width(32), .Chunk(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .x     (x),
    .y     (y),
`ifdef ADDSUB_SEQ_SAT_EN
    .sat   (sat),
`endif
    .fin   (fin),
    .so    (so),
    .couto (couto),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation and return just after the capture edge
  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
  endtask

  // Count edges until fin rises (bounded)
  task automatic wait_fin(output int l);
    l = 0;
    while (fin !== 1'b1 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic drop_req(input string tag);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk(tag, 32'(fin), 32'd0);
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z,
                           input logic n, input logic v);
    chk({tag, "_couto"}, 32'(couto), 32'(c));
    chk({tag, "_zero"},  32'(zero),  32'(z));
    chk({tag, "_neg"},   32'(neg),   32'(n));
    chk({tag, "_ovf"},   32'(ovf),   32'(v));
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = ADD; x = '0; y = '0;
`ifdef ADDSUB_SEQ_SAT_EN
    sat = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fin", 32'(fin), 32'd0);
    chk("rst_so", so, 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ADD wrapping to zero with carry out
    start(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("t1_fin_early", 32'(fin), 32'd0);
    wait_fin(lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_so", so, 32'h0);
    chk_flags("t1", 1'b1, 1'b1, 1'b0, 1'b0);
    drop_req("t1_fin_fall");
    chk("t1_so_hold", so, 32'h0);

    // ADC picks up the carry left by the previous ADD
    start(ADC, 32'h0, 32'h0);
    wait_fin(lat);
    chk("adc_latency", 32'(lat), 32'd4);
    chk("adc_so", so, 32'h1);
    chk_flags("adc", 1'b0, 1'b0, 1'b0, 1'b0);
    drop_req("adc_fin_fall");

    // SUB with borrow, then RSUB of the same operands
    start(SUB, 32'd5, 32'd7);
    wait_fin(lat);
    chk("sub_latency", 32'(lat), 32'd4);
    chk("sub_so", so, 32'hFFFF_FFFE);
    chk_flags("sub", 1'b1, 1'b0, 1'b1, 1'b0);
    drop_req("sub_fin_fall");

    start(RSUB, 32'd5, 32'd7);
    wait_fin(lat);
    chk("rsub_so", so, 32'h2);
    chk_flags("rsub", 1'b0, 1'b0, 1'b0, 1'b0);
    drop_req("rsub_fin_fall");

    // Signed overflow on subtract
    start(SUB, 32'h8000_0000, 32'h1);
    wait_fin(lat);
    chk("subovf_so", so, 32'h7FFF_FFFF);
    chk_flags("subovf", 1'b0, 1'b0, 1'b0, 1'b1);
    drop_req("subovf_fin_fall");

    // Signed overflow on add
    start(ADD, 32'h7FFF_FFFF, 32'h1);
    wait_fin(lat);
    chk("addovf_so", so, 32'h8000_0000);
    chk_flags("addovf", 1'b0, 1'b0, 1'b1, 1'b1);
    drop_req("addovf_fin_fall");

    // Operands changed during CALC are ignored; req held through DONE
    start(ADD, 32'h10, 32'h20);
    @(negedge clk);
    op = SUB; x = 32'hDEAD_BEEF; y = 32'h1234_5678;
    wait_fin(lat);
    chk("hold_latency", 32'(lat), 32'd4);
    chk("hold_so", so, 32'h30);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_fin", 32'(fin), 32'd1);
    end
    chk("hold_so_end", so, 32'h30);
    drop_req("hold_fin_fall");

    // req dropped during CALC: fin is a one-cycle pulse
    start(ADD, 32'h1, 32'h2);
    @(negedge clk);
    req = 1'b0;
    wait_fin(lat);
    chk("pulse_latency", 32'(lat), 32'd4);
    chk("pulse_so", so, 32'h3);
    @(posedge clk); #1;
    chk("pulse_fin_low", 32'(fin), 32'd0);
    chk("pulse_so_hold", so, 32'h3);

    // Reset two edges into CALC aborts immediately
    start(ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_fin", 32'(fin), 32'd0);
    chk("abort_so", so, 32'h0);
    chk_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    start(ADD, 32'd3, 32'd4);
    wait_fin(lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_so", so, 32'h7);
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    drop_req("post_rst_fin_fall");

`ifdef ADDSUB_SEQ_SAT_EN
    // Saturating subtract clamps to the negative limit
    sat = 1'b1;
    start(SUB, 32'h8000_0000, 32'h1);
    sat = 1'b0;
    wait_fin(lat);
    chk("sat_so", so, 32'h8000_0000);
    chk_flags("sat", 1'b0, 1'b0, 1'b1, 1'b1);
    drop_req("sat_fin_fall");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, clocked successor to the req/fin handshake subtractor in the Math library.
- Adds and subtracts, with reverse-subtract and add-with-carry modes.
- Processes operands digit-serially, Chunk bits per clock, trading latency for a narrow carry chain.
- Status flags are registered and presented on a four-phase req/fin handshake; feeds the ALU result mux.

Parameters:
- Width, 32, operand and result width in bits; must be ≥ 2.
- Chunk, 8, bits processed per clock; must divide Width. Derived N = Width/Chunk.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  request, four-phase handshake
- op  input  2  00 ADD x+y; 01 SUB x−y; 10 RSUB y−x; 11 ADC x+y+couto
- x  input  Width  operand A
- y  input  Width  operand B
- fin  output  1  result valid / handshake acknowledge
- so  output  Width  result
- couto  output  1  ADD/ADC: carry out; SUB/RSUB: borrow (1 when minuend < subtrahend, unsigned)
- zero  output  1  so == 0
- neg  output  1  so[Width−1]
- ovf  output  1  signed overflow

Behaviour:
- Reset (async, any state): state IDLE, fin=0, so=0, couto=0, zero=0, neg=0, ovf=0, chunk counter=0, internal registers cleared.
- IDLE:
  - On an edge with req=1, latch x, y and op, and latch carry-in:
    - ADD: 0.
    - SUB/RSUB: 1, with subtrahend inverted.
    - ADC: current couto.
  - Go to CALC with counter=0.
- CALC:
  - Each edge adds chunk [counter*Chunk +: Chunk] of the latched operands plus the running carry, stores the partial sum, then increments counter.
  - On the edge processing chunk N−1, update together: so, couto, zero, neg, ovf; set fin=1; go to DONE.
  - fin rises N edges after the capture edge (N=4 at default).
- DONE:
  - Hold fin=1 and all outputs while req=1.
  - On an edge with req=0: fin←0, go to IDLE.
- Outputs so and flags hold their last values until the next completion; they are not cleared on fin fall.
- couto semantics:
  - SUB/RSUB: couto = NOT final adder carry (borrow).
  - ADD/ADC: couto = final carry.
- ovf:
  - Add: operands the same sign, result sign differs.
  - Subtract: operands differ in sign, result sign ≠ minuend sign.
- Operand changes on x/y/op after the capture edge are ignored until the next IDLE capture.
- req toggling during CALC is ignored.
- req already low when DONE is entered: fin is high for exactly one cycle.
- Back-to-back throughput: one operation per N+2 cycles minimum.
- Reset mid-CALC or in DONE aborts the operation; no partial result is visible.
- Chunk == Width is legal: N=1, fin one edge after capture.

Optional Feature:
- Macro ADDSUB_SEQ_SAT_EN.
- Defined:
  - Extra input port sat (1 bit), latched at capture.
  - When the latched sat=1 and ovf=1, so clamps to the signed limit: 0x7FF…F if the true result is positive, 0x800…0 if negative.
  - ovf is still reported; zero and neg are computed from the clamped so.
  - couto is unaffected.
- Undefined:
  - Port sat absent; results always wrap modulo 2^Width.

Test Plan (Width=32, Chunk=8):
1. ADD x=0xFFFFFFFF, y=0x00000001 → fin high exactly 4 edges after capture; so=0, couto=1, zero=1, neg=0, ovf=0.
2. SUB x=5, y=7 → so=0xFFFFFFFE, couto=1 (borrow), neg=1, ovf=0; then RSUB same operands → so=2, couto=0.
3. SUB x=0x80000000, y=1 → so=0x7FFFFFFF, ovf=1, couto=0. With ADDSUB_SEQ_SAT_EN and sat=1 → so=0x80000000, ovf=1, neg=1.
4. Carry chain: ADD 0xFFFFFFFF+1 (couto=1), drop req, then ADC x=0, y=0 → so=1, couto=0.
5. Hold req=1 through DONE for 10 cycles; change x/y during CALC → no restart, fin stays high, so reflects the captured operands; fin falls one edge after req=0.
6. Assert rst two edges into CALC → fin=0, so=0, all flags 0 immediately (async); a subsequent ADD 3+4 completes with so=7 after 4 edges.
